// File: rtl/div_req_sched_if.sv
// Request/issue/response bundle between the datapath, the divide scheduler and the radix-2 divider.
// The slave modport is the scheduler; the master modport is its environment.
interface div_req_sched_if #(
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [7:0]       in_dividend;
   logic [7:0]       in_divisor;
   logic [TAG_W-1:0] in_tag;

   logic             div_opn_valid;
   logic             div_sign;
   logic [7:0]       div_dividend;
   logic [7:0]       div_divisor;
   logic             div_res_valid;
   logic [15:0]      div_result;
   logic             div_res_ready;

   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_quotient;
   logic [7:0]       out_remainder;
   logic [TAG_W-1:0] out_tag;
   logic             out_dbz;
   logic             out_err;

   modport slave (
      input  in_valid, in_sign, in_dividend, in_divisor, in_tag,
      input  div_res_valid, div_result, out_ready,
      output in_ready, div_opn_valid, div_sign, div_dividend, div_divisor, div_res_ready,
      output out_valid, out_quotient, out_remainder, out_tag, out_dbz, out_err
   );

   modport master (
      output in_valid, in_sign, in_dividend, in_divisor, in_tag,
      output div_res_valid, div_result, out_ready,
      input  in_ready, div_opn_valid, div_sign, div_dividend, div_divisor, div_res_ready,
      input  out_valid, out_quotient, out_remainder, out_tag, out_dbz, out_err
   );
endinterface

// File: rtl/div_req_sched.sv
// Divide request scheduler: FIFO-buffered requests issued one at a time to the divider, 2 cycles push-to-issue.
// in_ready = !full (no pass-through); a response holds in HOLD until out_ready, stalling further issues.
module div_req_sched_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_vld,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign full     = (cnt == FULL_CNT);
   assign empty    = (cnt == '0);
   assign do_push  = push_vld & ~full;
   assign do_pop   = pop_vld & ~empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

module div_req_sched #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic           clk,
   input  logic           rst_n,
   div_req_sched_if.slave io
);
   typedef struct packed {
      logic             sign;
      logic [7:0]       dividend;
      logic [7:0]       divisor;
      logic [TAG_W-1:0] tag;
   } req_t;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   localparam int RW = $bits(req_t);

   state_t           state, state_nxt;
   req_t             push_req, head;
   logic [RW-1:0]    head_raw;
   logic             fifo_full, fifo_empty;
   logic             pop, issue, ld_dbz, ld_res, ld_tmo, res_rdy;
   logic [5:0]       tmo_cnt, tmo_nxt;

   logic             opn_vld_q, sign_q, out_vld_q, dbz_q, err_q;
   logic [7:0]       dividend_q, divisor_q, quo_q, rem_q;
   logic [TAG_W-1:0] tag_q, out_tag_q;

   assign push_req = '{sign: io.in_sign, dividend: io.in_dividend,
                       divisor: io.in_divisor, tag: io.in_tag};
   assign head     = req_t'(head_raw);
   assign tmo_nxt  = tmo_cnt + 6'd1;

   div_req_sched_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (io.in_valid),
      .push_dat (push_req),
      .pop_vld  (pop),
      .head_dat (head_raw),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      issue     = 1'b0;
      ld_dbz    = 1'b0;
      ld_res    = 1'b0;
      ld_tmo    = 1'b0;
      res_rdy   = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head.divisor == 8'd0) begin
                  ld_dbz    = 1'b1;
                  state_nxt = HOLD;
               end else begin
                  issue     = 1'b1;
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            res_rdy = 1'b1;
            // A result landing on the last allowed cycle still wins over the abort.
            if (io.div_res_valid) begin
               ld_res    = 1'b1;
               state_nxt = HOLD;
            end else if (tmo_nxt == 6'(TIMEOUT)) begin
               ld_tmo    = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_vld_q && io.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tmo_cnt    <= '0;
         opn_vld_q  <= 1'b0;
         sign_q     <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         tag_q      <= '0;
         out_vld_q  <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
         out_tag_q  <= '0;
         dbz_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state     <= state_nxt;
         opn_vld_q <= issue;
         // out_valid trails entry into HOLD by one cycle and drops on the handshake.
         out_vld_q <= (state == HOLD) & ~(out_vld_q & io.out_ready);
         if (issue) begin
            sign_q     <= head.sign;
            dividend_q <= head.dividend;
            divisor_q  <= head.divisor;
            tag_q      <= head.tag;
            tmo_cnt    <= '0;
         end else if (state == WAIT) begin
            tmo_cnt <= tmo_nxt;
         end
         if (ld_dbz) begin
            quo_q     <= 8'hFF;
            rem_q     <= head.dividend;
            out_tag_q <= head.tag;
            dbz_q     <= 1'b1;
            err_q     <= 1'b0;
         end
         if (ld_res) begin
            quo_q     <= io.div_result[7:0];
            rem_q     <= io.div_result[15:8];
            out_tag_q <= tag_q;
            dbz_q     <= 1'b0;
            err_q     <= 1'b0;
         end
         if (ld_tmo) begin
            quo_q     <= '0;
            rem_q     <= '0;
            out_tag_q <= tag_q;
            dbz_q     <= 1'b0;
            err_q     <= 1'b1;
         end
      end
   end

   assign io.in_ready      = ~fifo_full;
   assign io.div_opn_valid = opn_vld_q;
   assign io.div_sign      = sign_q;
   assign io.div_dividend  = dividend_q;
   assign io.div_divisor   = divisor_q;
   assign io.div_res_ready = res_rdy;
   assign io.out_valid     = out_vld_q;
   assign io.out_quotient  = quo_q;
   assign io.out_remainder = rem_q;
   assign io.out_tag       = out_tag_q;
   assign io.out_dbz       = dbz_q;
   assign io.out_err       = err_q;
endmodule

// File: tb/tb_div_req_sched.sv
// Directed bench for div_req_sched: behavioural divider model plus hand-computed expected responses.
module tb_div_req_sched;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic              respond;
   logic              inject;
   int                mdelay;
   logic              mvld, mbusy, hs;
   int                mdly;
   logic [15:0]       mres;
   logic signed [7:0] sa, sb, sq, sr;
   int                n_ov, n_opn;

   logic [7:0] bp_dd [5] = '{8'd50, 8'd77, 8'd200, 8'd13, 8'd255};
   logic [7:0] bp_dv [5] = '{8'd2,  8'd3,  8'd9,   8'd5,  8'd16};
   logic [7:0] bp_q  [5] = '{8'd25, 8'd25, 8'd22,  8'd2,  8'd15};
   logic [7:0] bp_r  [5] = '{8'd0,  8'd2,  8'd2,   8'd3,  8'd15};

   div_req_sched_if #(.TAG_W(4)) dif ();

   div_req_sched #(.DEPTH(4), .TAG_W(4), .TIMEOUT(31)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Divider model: answers mdelay+1 cycles after the start pulse when respond is set.
   initial begin
      dif.div_res_valid = 1'b0;
      dif.div_result    = '0;
      mvld = 1'b0; mbusy = 1'b0; mdly = 0; mres = '0; hs = 1'b0;
      forever begin
         @(negedge clk);
         hs = dif.div_res_valid & dif.div_res_ready;
         @(posedge clk);
         #1;
         if (hs || !rst_n) begin
            mvld  = 1'b0;
            mbusy = 1'b0;
         end
         if (rst_n && dif.div_opn_valid) begin
            mvld  = 1'b0;
            mbusy = 1'b1;
            mdly  = mdelay;
            if (dif.div_sign) begin
               sa = dif.div_dividend; sb = dif.div_divisor;
               sq = sa / sb;          sr = sa % sb;
               mres = {sr, sq};
            end else begin
               mres = {dif.div_dividend % dif.div_divisor, dif.div_dividend / dif.div_divisor};
            end
         end else if (mbusy && !mvld) begin
            if (mdly != 0) mdly--;
            else if (respond) mvld = 1'b1;
         end
         dif.div_res_valid = mvld | inject;
         dif.div_result    = inject ? 16'hABCD : mres;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic s, input logic [7:0] a, input logic [7:0] b, input logic [3:0] t);
      check("push_in_ready", dif.in_ready, 1'b1);
      dif.in_valid    = 1'b1;
      dif.in_sign     = s;
      dif.in_dividend = a;
      dif.in_divisor  = b;
      dif.in_tag      = t;
      tick();
      dif.in_valid = 1'b0;
   endtask

   task automatic wait_ov(input string tag);
      int n;
      n = 0;
      while (!dif.out_valid && n < 80) begin
         tick();
         n++;
      end
      check(tag, dif.out_valid, 1'b1);
   endtask

   task automatic take();
      dif.out_ready = 1'b1;
      tick();
      dif.out_ready = 1'b0;
      check("hs_drop", dif.out_valid, 1'b0);
   endtask

   task automatic check_resp(input string tag, input logic [7:0] q, input logic [7:0] r,
                             input logic [3:0] t, input logic dbz, input logic err);
      check(tag, {dif.out_quotient, dif.out_remainder, dif.out_tag, dif.out_dbz, dif.out_err},
            {q, r, t, dbz, err});
   endtask

   initial begin
      total = 0; bad = 0;
      respond = 1'b1; inject = 1'b0; mdelay = 2;
      rst_n = 1'b0;
      dif.in_valid = 1'b0; dif.in_sign = 1'b0; dif.in_dividend = '0;
      dif.in_divisor = '0; dif.in_tag = '0; dif.out_ready = 1'b0;
      repeat (2) tick();
      check("rst_outs", {dif.div_opn_valid, dif.div_sign, dif.div_dividend, dif.div_divisor,
                         dif.out_valid, dif.out_quotient, dif.out_remainder, dif.out_tag,
                         dif.out_dbz, dif.out_err}, '0);
      check("rst_in_ready", dif.in_ready, 1'b1);
      rst_n = 1'b1;
      tick();

      // Unsigned 100/7
      push(1'b0, 8'd100, 8'd7, 4'd3);
      check("u_no_early_issue", dif.div_opn_valid, 1'b0);
      tick();
      check("u_issue", {dif.div_opn_valid, dif.div_sign, dif.div_dividend, dif.div_divisor},
            {1'b1, 1'b0, 8'd100, 8'd7});
      tick();
      check("u_pulse_once", dif.div_opn_valid, 1'b0);
      wait_ov("u_valid");
      check_resp("u_resp", 8'd14, 8'd2, 4'd3, 1'b0, 1'b0);
      take();

      // Signed -7/2
      push(1'b1, 8'hF9, 8'h02, 4'd5);
      tick();
      check("s_issue", {dif.div_opn_valid, dif.div_sign, dif.div_dividend, dif.div_divisor},
            {1'b1, 1'b1, 8'hF9, 8'h02});
      wait_ov("s_valid");
      check_resp("s_resp", 8'hFD, 8'hFF, 4'd5, 1'b0, 1'b0);
      take();

      // Divide by zero 55/0
      push(1'b0, 8'd55, 8'd0, 4'd9);
      check("z_valid_e0", dif.out_valid, 1'b0);
      tick();
      check("z_e1", {dif.out_valid, dif.div_opn_valid}, 2'b00);
      tick();
      check("z_e2", {dif.out_valid, dif.div_opn_valid}, 2'b10);
      check_resp("z_resp", 8'hFF, 8'd55, 4'd9, 1'b1, 1'b0);
      take();

      // Back-pressure: five pushes, one in flight plus four queued
      for (int i = 0; i < 5; i++) push(1'b0, bp_dd[i], bp_dv[i], 4'(i + 1));
      check("bp_full", dif.in_ready, 1'b0);
      repeat (10) tick();
      check("bp_stall", {dif.in_ready, dif.out_valid, dif.out_tag}, {1'b0, 1'b1, 4'd1});
      for (int i = 0; i < 5; i++) begin
         wait_ov("bp_valid");
         check_resp("bp_resp", bp_q[i], bp_r[i], 4'(i + 1), 1'b0, 1'b0);
         take();
      end
      check("bp_drained", dif.in_ready, 1'b1);

      // Timeout, then a late result that must be ignored
      respond = 1'b0;
      push(1'b0, 8'd33, 8'd4, 4'd7);
      tick();
      check("t_issue", dif.div_opn_valid, 1'b1);
      repeat (31) tick();
      check("t_not_yet", dif.out_valid, 1'b0);
      tick();
      check("t_valid", dif.out_valid, 1'b1);
      check_resp("t_resp", 8'd0, 8'd0, 4'd7, 1'b0, 1'b1);
      inject = 1'b1;
      tick();
      inject = 1'b0;
      repeat (2) tick();
      check_resp("t_late_ignored", 8'd0, 8'd0, 4'd7, 1'b0, 1'b1);
      check("t_late_valid", dif.out_valid, 1'b1);
      take();
      respond = 1'b1;
      push(1'b0, 8'd90, 8'd10, 4'd2);
      wait_ov("t_next_valid");
      check_resp("t_next_resp", 8'd9, 8'd0, 4'd2, 1'b0, 1'b0);
      take();

      // Result on the final allowed cycle beats the timeout
      mdelay = 29;
      push(1'b0, 8'd120, 8'd11, 4'd6);
      tick();
      repeat (31) tick();
      check("p_not_yet", dif.out_valid, 1'b0);
      tick();
      check("p_valid", dif.out_valid, 1'b1);
      check_resp("p_resp", 8'd10, 8'd10, 4'd6, 1'b0, 1'b0);
      take();
      mdelay = 2;

      // Reset while one request waits and three are queued
      respond = 1'b0;
      for (int i = 0; i < 4; i++) push(1'b0, 8'd40 + 8'(i), 8'd3, 4'(i + 10));
      repeat (3) tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("r_outs", {dif.div_opn_valid, dif.div_sign, dif.div_dividend, dif.div_divisor,
                       dif.out_valid, dif.out_quotient, dif.out_remainder, dif.out_tag,
                       dif.out_dbz, dif.out_err}, '0);
      check("r_in_ready", dif.in_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      respond = 1'b1;
      n_ov = 0; n_opn = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dif.out_valid) n_ov++;
         if (dif.div_opn_valid) n_opn++;
      end
      check("r_no_resp", n_ov, 0);
      check("r_no_issue", n_opn, 0);
      push(1'b0, 8'd9, 8'd3, 4'd4);
      wait_ov("r_after_valid");
      check_resp("r_after_resp", 8'd3, 8'd0, 4'd4, 1'b0, 1'b0);
      take();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
